// File: rtl/riscvibe_mem_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch and load/store.
// Optional RISCVIBE_ARB_PERF_EN adds blocked-request cycle counters.
module riscvibe_mem_arbiter #(
    parameter int DATA_MAX_CONSEC = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_gnt_o,
    output logic        if_rvalid_o,
    output logic [31:0] if_rdata_o,
    input  logic        flush_i,
    input  logic        d_req_i,
    input  logic        d_we_i,
    input  logic [31:0] d_addr_i,
    input  logic [3:0]  d_be_i,
    input  logic [31:0] d_wdata_i,
    output logic        d_gnt_o,
    output logic        d_rvalid_o,
    output logic [31:0] d_rdata_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
`ifdef RISCVIBE_ARB_PERF_EN
    ,
    output logic [31:0] if_wait_cnt_o,
    output logic [31:0] d_wait_cnt_o
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_e;

    localparam logic [3:0] MAX_C = 4'(DATA_MAX_CONSEC);

    state_e      state_q, state_d;
    logic        owner_q, owner_d;   // 0 = fetch, 1 = data
    logic        drop_q, drop_d;
    logic [3:0]  consec_q, consec_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic        if_ok, d_win;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            owner_q  <= 1'b0;
            drop_q   <= 1'b0;
            consec_q <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            drop_q   <= drop_d;
            consec_q <= consec_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        drop_d   = drop_q;
        consec_d = consec_q;
        we_d     = we_q;
        addr_d   = addr_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        case (state_q)
            S_IDLE: begin
                drop_d = 1'b0;
                if (d_gnt_o) begin
                    owner_d = 1'b1;
                    we_d    = d_we_i;
                    addr_d  = d_addr_i;
                    be_d    = d_be_i;
                    wdata_d = d_wdata_i;
                    state_d = S_ISSUE;
                end else if (if_gnt_o) begin
                    owner_d = 1'b0;
                    we_d    = 1'b0;
                    addr_d  = if_addr_i;
                    be_d    = 4'hF;
                    wdata_d = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (flush_i && !owner_q) drop_d = 1'b1;
                if (mem_gnt_i) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (flush_i && !owner_q) drop_d = 1'b1;
                if (mem_rvalid_i) begin
                    state_d = S_IDLE;
                    drop_d  = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Fairness count only accumulates while a fetch is actually waiting
        if (!if_req_i || if_gnt_o) consec_d = '0;
        else if (d_gnt_o && consec_q != MAX_C) consec_d = consec_q + 4'd1;
    end

    always_comb begin
        if_ok       = if_req_i && !flush_i;
        d_win       = d_req_i && !(if_ok && consec_q == MAX_C);
        if_gnt_o    = 1'b0;
        d_gnt_o     = 1'b0;
        if_rvalid_o = 1'b0;
        d_rvalid_o  = 1'b0;
        // Grants are combinational, so keep them quiet while reset is held
        if (rst_n && state_q == S_IDLE) begin
            d_gnt_o  = d_win;
            if_gnt_o = if_ok && !d_win;
        end
        if (state_q == S_WAIT && mem_rvalid_i) begin
            d_rvalid_o  = owner_q;
            if_rvalid_o = !owner_q && !drop_q && !flush_i;
        end
    end

    assign mem_req_o   = (state_q == S_ISSUE);
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_be_o    = be_q;
    assign mem_wdata_o = wdata_q;
    assign if_rdata_o  = mem_rdata_i;
    assign d_rdata_o   = mem_rdata_i;

`ifdef RISCVIBE_ARB_PERF_EN
    logic [31:0] if_wait_q, if_wait_d, d_wait_q, d_wait_d;

    always_comb begin
        if_wait_d = if_wait_q + {31'd0, (if_req_i && !if_gnt_o)};
        d_wait_d  = d_wait_q + {31'd0, (d_req_i && !d_gnt_o)};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_wait_q <= '0;
            d_wait_q  <= '0;
        end else begin
            if_wait_q <= if_wait_d;
            d_wait_q  <= d_wait_d;
        end
    end

    assign if_wait_cnt_o = if_wait_q;
    assign d_wait_cnt_o  = d_wait_q;
`endif

endmodule

// File: tb/tb_riscvibe_mem_arbiter.sv
// Self-checking bench for riscvibe_mem_arbiter: directed scenarios plus randomized
// transactions checked against a requester/memory-level reference model.
module tb_riscvibe_mem_arbiter;

    localparam int MAXC = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req_i, flush_i, d_req_i, d_we_i, mem_gnt_i, mem_rvalid_i;
    logic [31:0] if_addr_i, d_addr_i, d_wdata_i, mem_rdata_i;
    logic [3:0]  d_be_i;
    logic        if_gnt_o, if_rvalid_o, d_gnt_o, d_rvalid_o, mem_req_o, mem_we_o;
    logic [31:0] if_rdata_o, d_rdata_o, mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_be_o;
`ifdef RISCVIBE_ARB_PERF_EN
    logic [31:0] if_wait_cnt_o, d_wait_cnt_o;
    int unsigned m_ifw, m_dw;
`endif

    always #5 clk = ~clk;

    riscvibe_mem_arbiter #(.DATA_MAX_CONSEC(MAXC)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o), .flush_i(flush_i),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_be_i(d_be_i),
        .d_wdata_i(d_wdata_i), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o),
        .d_rdata_o(d_rdata_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
`ifdef RISCVIBE_ARB_PERF_EN
        , .if_wait_cnt_o(if_wait_cnt_o), .d_wait_cnt_o(d_wait_cnt_o)
`endif
    );

    int tests = 0;
    int fails = 0;
    int m_consec;
    int last_win;   // 0 none, 1 fetch, 2 data
    bit          if_pend, d_pend, d_we_v;
    logic [31:0] if_addr_v, d_addr_v, d_wdata_v;
    logic [3:0]  d_be_v;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req();
        if_req_i  = if_pend;
        if_addr_i = if_addr_v;
        d_req_i   = d_pend;
        d_we_i    = d_we_v;
        d_addr_i  = d_addr_v;
        d_be_i    = d_be_v;
        d_wdata_i = d_wdata_v;
    endtask

    // Requester-level model of the fairness rule and blocked-cycle counters
    task automatic model_cycle(input bit ifr, input bit dr, input bit gi, input bit gd);
        if (!ifr || gi) m_consec = 0;
        else if (gd && m_consec < MAXC) m_consec++;
`ifdef RISCVIBE_ARB_PERF_EN
        if (ifr && !gi) m_ifw++;
        if (dr && !gd) m_dw++;
`endif
    endtask

    task automatic run_txn(input int gdly, input int rlat, input bit fl_idle,
                           input bit fl_issue, input bit fl_wait, input logic [31:0] rdata);
        bit exp_if, exp_d, if_ok, own_d, dropped;
        logic [31:0] e_addr, e_wdata;
        logic [3:0]  e_be;
        logic        e_we;
        drive_req();
        flush_i      = fl_idle;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'($urandom);
        mem_rdata_i  = $urandom;
        if_ok  = if_pend && !fl_idle;
        exp_d  = d_pend && !(if_ok && m_consec == MAXC);
        exp_if = if_ok && !exp_d;
        @(negedge clk);
        chk("idle_if_gnt", if_gnt_o, exp_if);
        chk("idle_d_gnt", d_gnt_o, exp_d);
        chk("idle_mem_req", mem_req_o, 0);
        chk("idle_rvalid", {if_rvalid_o, d_rvalid_o}, 0);
        model_cycle(if_pend, d_pend, exp_if, exp_d);
        last_win = exp_d ? 2 : (exp_if ? 1 : 0);
        own_d = exp_d;
        e_we = 1'b0; e_addr = if_addr_v; e_be = 4'hF; e_wdata = '0;
        if (exp_d) begin
            e_we = d_we_v; e_addr = d_addr_v; e_be = d_be_v; e_wdata = d_wdata_v;
            d_pend = 1'b0;
        end else if (exp_if) begin
            if_pend = 1'b0;
        end
        next_cyc();
        mem_rvalid_i = 1'b0;
        flush_i      = 1'b0;
        drive_req();
        if (!exp_if && !exp_d) return;
        dropped = 1'b0;
        for (int k = 0; k <= gdly; k++) begin
            drive_req();
            mem_gnt_i = (k == gdly);
            flush_i   = fl_issue && (k == 0);
            if (flush_i && !own_d) dropped = 1'b1;
            @(negedge clk);
            chk("issue_mem_req", mem_req_o, 1);
            chk("issue_addr", mem_addr_o, e_addr);
            chk("issue_we", mem_we_o, e_we);
            chk("issue_be", mem_be_o, e_be);
            chk("issue_wdata", mem_wdata_o, e_wdata);
            chk("issue_gnt", {if_gnt_o, d_gnt_o}, 0);
            chk("issue_rvalid", {if_rvalid_o, d_rvalid_o}, 0);
            model_cycle(if_pend, d_pend, 1'b0, 1'b0);
            next_cyc();
        end
        mem_gnt_i = 1'b0;
        for (int k = 0; k <= rlat; k++) begin
            drive_req();
            flush_i      = fl_wait && (k == 0);
            if (flush_i && !own_d) dropped = 1'b1;
            mem_rvalid_i = (k == rlat);
            mem_rdata_i  = (k == rlat) ? rdata : $urandom;
            @(negedge clk);
            chk("wait_mem_req", mem_req_o, 0);
            chk("wait_gnt", {if_gnt_o, d_gnt_o}, 0);
            chk("wait_if_rvalid", if_rvalid_o, (k == rlat) && !own_d && !dropped);
            chk("wait_d_rvalid", d_rvalid_o, (k == rlat) && own_d);
            if (k == rlat) begin
                if (own_d) chk("d_rdata", d_rdata_o, rdata);
                else       chk("if_rdata", if_rdata_o, rdata);
            end
            model_cycle(if_pend, d_pend, 1'b0, 1'b0);
            next_cyc();
        end
        mem_rvalid_i = 1'b0;
        flush_i      = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        if_pend = 0; d_pend = 0; d_we_v = 0;
        if_addr_v = '0; d_addr_v = '0; d_wdata_v = '0; d_be_v = '0;
        drive_req();
        flush_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;
        m_consec = 0;
`ifdef RISCVIBE_ARB_PERF_EN
        m_ifw = 0; m_dw = 0;
`endif
        #13;
        chk("rst_mem_req", mem_req_o, 0);
        chk("rst_payload", mem_addr_o | mem_wdata_o, 0);
        chk("rst_we_be", {mem_we_o, mem_be_o}, 0);
        chk("rst_gnt_rvalid", {if_gnt_o, d_gnt_o, if_rvalid_o, d_rvalid_o}, 0);
        next_cyc();
        rst_n = 1'b1;
        next_cyc();

        // Single fetch
        if_pend = 1; if_addr_v = 32'h100;
        run_txn(0, 0, 0, 0, 0, 32'h0050_0093);
        chk("s1_winner", last_win, 1);

        // Store with delayed memory grant
        d_pend = 1; d_we_v = 1; d_addr_v = 32'h2004; d_be_v = 4'b0011; d_wdata_v = 32'hBEEF;
        run_txn(3, 1, 0, 0, 0, 32'h0);
        chk("s2_winner", last_win, 2);

        // Both ports saturated: fairness pattern
        run_txn(0, 0, 0, 0, 0, 32'h0);
        for (int i = 0; i < 10; i++) begin
            if_pend = 1; if_addr_v = 32'h400 + 32'(i * 4);
            d_pend = 1; d_we_v = 0; d_addr_v = 32'h8000 + 32'(i * 4); d_be_v = 4'hF;
            run_txn(0, 0, 0, 0, 0, $urandom);
            chk("s3_order", last_win, (i % 5 == 4) ? 1 : 2);
        end
        if_pend = 0; d_pend = 0;
`ifdef RISCVIBE_ARB_PERF_EN
        chk("perf_if_wait", if_wait_cnt_o, m_ifw);
        chk("perf_d_wait", d_wait_cnt_o, m_dw);
`endif

        // Flush of an in-flight fetch, then a normal fetch
        if_pend = 1; if_addr_v = 32'h300;
        run_txn(1, 1, 0, 0, 1, 32'hDEAD_0001);
        if_pend = 1; if_addr_v = 32'h800;
        run_txn(0, 0, 0, 0, 0, 32'h1234_5678);
        chk("s4_refetch", last_win, 1);

        // Reset while a load waits for its response
        d_pend = 1; d_we_v = 0; d_addr_v = 32'h44; d_be_v = 4'hF;
        drive_req();
        @(negedge clk);
        chk("s5_d_gnt", d_gnt_o, 1);
        d_pend = 0;
        next_cyc();
        drive_req();
        mem_gnt_i = 1;
        @(negedge clk);
        chk("s5_issue", mem_req_o, 1);
        next_cyc();
        mem_gnt_i = 0;
        if_pend = 1; if_addr_v = 32'h200;
        drive_req();
        #2;
        rst_n = 1'b0;
        #1;
        chk("s5_rst_gnt", {if_gnt_o, d_gnt_o}, 0);
        chk("s5_rst_rvalid", {if_rvalid_o, d_rvalid_o}, 0);
        chk("s5_rst_mem", {mem_req_o, mem_we_o, mem_be_o}, 0);
        chk("s5_rst_payload", mem_addr_o | mem_wdata_o, 0);
        next_cyc();
        rst_n = 1'b1;
        m_consec = 0;
`ifdef RISCVIBE_ARB_PERF_EN
        m_ifw = 0; m_dw = 0;
`endif
        run_txn(0, 0, 0, 0, 0, 32'hCAFE_F00D);
        chk("s5_first_gnt", last_win, 1);

        // Randomized traffic
        for (int i = 0; i < 80; i++) begin
            if (!if_pend && ($urandom_range(0, 3) != 0)) begin
                if_pend = 1; if_addr_v = {$urandom, 2'b00} >> 0;
                if_addr_v[1:0] = 2'b00;
            end
            if (!d_pend && ($urandom_range(0, 2) != 0)) begin
                d_pend = 1; d_we_v = 1'($urandom); d_addr_v = $urandom;
                d_be_v = 4'($urandom); d_wdata_v = $urandom;
            end
            run_txn($urandom_range(0, 3), $urandom_range(0, 2),
                    ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
                    ($urandom_range(0, 5) == 0), $urandom);
        end
`ifdef RISCVIBE_ARB_PERF_EN
        chk("perf_if_wait_end", if_wait_cnt_o, m_ifw);
        chk("perf_d_wait_end", d_wait_cnt_o, m_dw);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
